// File: rtl/seq_div16.sv
// ============================================================================
// seq_div16 - sequential unsigned restoring divider, 16-bit / 8-bit.
//
// Produces one quotient bit per clock. An operation takes 16 iteration cycles
// after the accepting edge. A zero divisor completes at once with an all-ones
// quotient, r = a[7:0] and dbz set. For a valid divisor the result satisfies
// a == q*b + r with r < b.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset, clears all state
//   start  in   1   request a division; sampled only while idle
//   a      in  16   dividend, captured on the accepting edge
//   b      in   8   divisor, captured on the accepting edge
//   busy   out  1   high while iterations are in progress
//   done   out  1   one-cycle completion pulse; q, r, dbz valid in that cycle
//   dbz    out  1   divide-by-zero flag of the last completed operation
//   q      out 16   quotient, held until the next completion
//   r      out  8   remainder, held until the next completion
// ============================================================================
module seq_div16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic [15:0] q,
    output logic [7:0]  r
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [15:0] dvd;      // dividend shift register
    logic [7:0]  dvs;      // latched divisor
    logic [8:0]  pr;       // partial remainder, one spare bit for the compare
    logic [15:0] quo;      // quotient shift register
    logic [3:0]  cnt;      // iterations remaining after the current one

    logic        accept;   // valid division accepted this edge
    logic        zero_div; // divide-by-zero request completes this edge
    logic        finish;   // last iteration happens this edge

    logic [8:0]  pr_sh;
    logic [8:0]  pr_nx;
    logic        qbit;

    // One restoring step: compare the shifted partial remainder against the
    // zero-extended divisor and subtract when it fits. Result is {qbit, pr}.
    function automatic logic [9:0] trial_sub(input logic [8:0] pr_in,
                                             input logic [7:0] div_in);
        logic [8:0] div_ext;
        div_ext = {1'b0, div_in};
        if (pr_in >= div_ext) begin
            trial_sub = {1'b1, pr_in - div_ext};
        end else begin
            trial_sub = {1'b0, pr_in};
        end
    endfunction

    assign pr_sh          = {pr[7:0], dvd[15]};
    assign {qbit, pr_nx}  = trial_sub(pr_sh, dvs);
    assign busy           = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        zero_div = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (b != 8'd0) begin
                        accept   = 1'b1;
                        state_nx = RUN;
                    end else begin
                        zero_div = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt == 4'd0) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd  <= '0;
            dvs  <= '0;
            pr   <= '0;
            quo  <= '0;
            cnt  <= '0;
            done <= 1'b0;
            dbz  <= 1'b0;
            q    <= '0;
            r    <= '0;
        end else begin
            done <= finish | zero_div;

            if (accept) begin
                dvd <= a;
                dvs <= b;
                pr  <= '0;
                quo <= '0;
                cnt <= 4'd15;
            end

            if (state == RUN) begin
                dvd <= {dvd[14:0], 1'b0};
                pr  <= pr_nx;
                quo <= {quo[14:0], qbit};
                if (!finish) begin
                    cnt <= cnt - 4'd1;
                end
            end

            // The final quotient bit and remainder come from this edge's step,
            // so the outputs take the freshly computed values directly.
            if (finish) begin
                q   <= {quo[14:0], qbit};
                r   <= pr_nx[7:0];
                dbz <= 1'b0;
            end

            if (zero_div) begin
                q   <= 16'hFFFF;
                r   <= a[7:0];
                dbz <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_div16.sv
// ============================================================================
// tb_seq_div16 - self-checking bench for seq_div16.
// Expected results are queued when a request is issued and compared by the
// completion monitor on every done pulse; each test task adds its own checks
// on latency, busy behaviour and reset.
// ============================================================================
module tb_seq_div16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [15:0] q;
    logic [7:0]  r;

    int n_checks = 0;
    int n_fail   = 0;

    logic [24:0] exp_q[$];   // {q, r, dbz}

    seq_div16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .q     (q),
        .r     (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got q=%0d r=%0d dbz=%0b, required no completion", q, r, dbz);
            end else begin
                e = exp_q.pop_front();
                if ({q, r, dbz} !== e) begin
                    n_fail++;
                    $display("FAIL result: got q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                             q, r, dbz, e[24:9], e[8:1], e[0]);
                end
            end
        end
    end

    // Drive one start pulse and queue its expected result. Returns on the
    // falling edge right after the accepting edge.
    task automatic issue(input logic [15:0] ta, input logic [7:0] tb);
        @(negedge clk);
        a     = ta;
        b     = tb;
        start = 1'b1;
        if (tb == 8'd0) exp_q.push_back({16'hFFFF, ta[7:0], 1'b1});
        else            exp_q.push_back({ta / {8'd0, tb}, 8'(ta % {8'd0, tb}), 1'b0});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; counts cycles waited and cycles busy was seen.
    task automatic wait_done(input int limit, output int cycles, output int busy_cyc, output bit ok);
        cycles   = 0;
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (busy === 1'b1) busy_cyc++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 16'hABCD;
        b     = 8'h55;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, dbz, q, r} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%0b done=%0b dbz=%0b q=%0d r=%0d, required all 0", busy, done, dbz, q, r);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc, bcyc;
        bit ok;
        issue(16'd1000, 8'd7);
        wait_done(40, cyc, bcyc, ok);
        n_checks++;
        if (!ok || cyc != 16) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles (done=%0b), required 16", cyc, ok);
        end
        n_checks++;
        if (bcyc != 16) begin
            n_fail++;
            $display("FAIL basic_busy: got busy for %0d cycles, required 16", bcyc);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || q !== 16'd142 || r !== 8'd6) begin
            n_fail++;
            $display("FAIL basic_hold: got done=%0b q=%0d r=%0d, required done=0 q=142 r=6", done, q, r);
        end
    endtask

    task automatic test_corners();
        int cyc, bcyc;
        bit ok;
        logic [15:0] ta[4] = '{16'hFFFF, 16'hFFFF, 16'd200, 16'd0};
        logic [7:0]  tb[4] = '{8'hFF, 8'd1, 8'd250, 8'd5};
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i]);
            wait_done(40, cyc, bcyc, ok);
            n_checks++;
            if (!ok || cyc != 16) begin
                n_fail++;
                $display("FAIL corner_latency[%0d]: got %0d cycles (done=%0b), required 16", i, cyc, ok);
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc, bcyc;
        bit ok;
        issue(16'h1234, 8'd0);
        n_checks++;
        if (done !== 1'b1 || dbz !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_immediate: got done=%0b dbz=%0b busy=%0b, required 1 1 0", done, dbz, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dbz !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_after: got done=%0b busy=%0b dbz=%0b, required 0 0 1", done, busy, dbz);
        end
        issue(16'd100, 8'd10);
        wait_done(40, cyc, bcyc, ok);
        n_checks++;
        if (!ok || dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_clear: got done=%0b dbz=%0b, required done=1 dbz=0", ok, dbz);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        bit ok;
        issue(16'd1000, 8'd7);           // now just after E0
        repeat (4) @(negedge clk);       // after E4
        a     = 16'd50;
        b     = 8'd3;
        start = 1'b1;                    // sampled on E5, must be ignored
        @(negedge clk);
        start = 1'b0;
        wait_done(40, cyc, bcyc, ok);
        n_checks++;
        if (!ok || cyc != 11) begin
            n_fail++;
            $display("FAIL ignore_start_latency: got %0d cycles (done=%0b), required 11", cyc, ok);
        end
        // Start on the done cycle; sampled on E17.
        a     = 16'd50;
        b     = 8'd3;
        start = 1'b1;
        exp_q.push_back({16'd16, 8'd2, 1'b0});
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%0b done=%0b, required 1 0", busy, done);
        end
        wait_done(40, cyc, bcyc, ok);
        n_checks++;
        if (!ok || cyc != 16 || q !== 16'd16 || r !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_result: got %0d cycles q=%0d r=%0d, required 16 cycles q=16 r=2", cyc, q, r);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bcyc;
        bit ok;
        bit seen_done;
        issue(16'd1000, 8'd7);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        void'(exp_q.pop_back());         // the aborted operation never completes
        #1;
        n_checks++;
        if ({busy, done, dbz, q, r} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%0b done=%0b dbz=%0b q=%0d r=%0d, required all 0", busy, done, dbz, q, r);
        end
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
            if (busy === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL reset_abort: got activity during reset, required none");
        end
        rst_n = 1'b1;
        issue(16'd1000, 8'd7);
        wait_done(40, cyc, bcyc, ok);
        n_checks++;
        if (!ok || cyc != 16) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d cycles (done=%0b), required 16", cyc, ok);
        end
    endtask

    task automatic test_random();
        int cyc, bcyc;
        bit ok;
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [31:0] recon;
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            issue(ra, rb);
            wait_done(40, cyc, bcyc, ok);
            recon = 32'(q) * 32'(rb) + 32'(r);
            n_checks++;
            if (!ok || recon !== 32'(ra) || r >= rb) begin
                n_fail++;
                $display("FAIL random_identity: a=%0d b=%0d got q=%0d r=%0d done=%0b, required a==q*b+r and r<b",
                         ra, rb, q, r, ok);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_done: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
